// File: rtl/param_serializer.sv
// param_serializer
//   Parallel-to-serial shifter that sits between the TX data source and the
//   UART TX framing FSM. Words arrive over a valid/ready handshake into a
//   one-entry holding register. From there they are loaded into the shifter
//   and sent one bit per `enable` tick.
//
// Optional feature (compile-time macro): SER_PARITY_EN
//   When defined, a parity bit (^word XOR PARITY_ODD) follows the data bits.
//   Each frame is then DATA_WIDTH+1 bit periods long.
//
// Parameters
//   DATA_WIDTH  bits per word (2..32)
//   LSB_FIRST   1 = bit 0 first, 0 = bit DATA_WIDTH-1 first
//   IDLE_LEVEL  level driven on data_out while not shifting
//   PARITY_ODD  parity sense (0 even, 1 odd); only used with SER_PARITY_EN
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   data_in   parallel word
//   valid     data_in valid this cycle
//   ready     holding register empty (word accepted on valid && ready)
//   enable    bit-period tick from the baud generator
//   data_out  registered serial bit
//   busy      a word is in the shifter
//   done      one-cycle pulse when the last bit period of a word completes
module param_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter int   LSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  enable,
  output logic                  data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
  // PARITY_ODD has no effect in this build.
  localparam int unused_parity_odd = PARITY_ODD;
`endif

  state_t                r_state,     w_nxt_state;
  logic [DATA_WIDTH-1:0] r_hold_q,    w_nxt_hold_q;
  logic                  r_hold_full, w_nxt_hold_full;
  logic [DATA_WIDTH-1:0] r_shift_q,   w_nxt_shift_q;
  logic [CNT_W-1:0]      r_bit_cnt,   w_nxt_bit_cnt;
  logic                  r_data_out,  w_nxt_data_out;
  logic                  r_done,      w_nxt_done;
`ifdef SER_PARITY_EN
  logic                  r_parity,    w_nxt_parity;
`endif
  logic                  w_accept;

  // Handshake depends only on the holding flag, so valid never reaches ready.
  assign ready    = !r_hold_full;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign data_out = r_data_out;
  assign w_accept = valid && !r_hold_full;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold_q    <= '0;
      r_hold_full <= 1'b0;
      r_shift_q   <= '0;
      r_bit_cnt   <= '0;
      r_data_out  <= IDLE_LEVEL;
      r_done      <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_hold_q    <= w_nxt_hold_q;
      r_hold_full <= w_nxt_hold_full;
      r_shift_q   <= w_nxt_shift_q;
      r_bit_cnt   <= w_nxt_bit_cnt;
      r_data_out  <= w_nxt_data_out;
      r_done      <= w_nxt_done;
`ifdef SER_PARITY_EN
      r_parity    <= w_nxt_parity;
`endif
    end
  end

  // Next-state, handshake and shifter update.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_hold_q    = r_hold_q;
    w_nxt_hold_full = r_hold_full;
    w_nxt_shift_q   = r_shift_q;
    w_nxt_bit_cnt   = r_bit_cnt;
    w_nxt_data_out  = r_data_out;
    w_nxt_done      = 1'b0;
`ifdef SER_PARITY_EN
    w_nxt_parity    = r_parity;
`endif

    // Accept and load are mutually exclusive: a load needs hold_full=1,
    // which also blocks acceptance in the same cycle.
    if (w_accept) begin
      w_nxt_hold_q    = data_in;
      w_nxt_hold_full = 1'b1;
    end else begin
      w_nxt_hold_q    = r_hold_q;
    end

    case (r_state)
      S_IDLE: begin
        w_nxt_data_out = IDLE_LEVEL;
        if (r_hold_full) begin
          w_nxt_shift_q   = r_hold_q;
          w_nxt_hold_full = 1'b0;
          w_nxt_bit_cnt   = '0;
          w_nxt_state     = S_SHIFT;
`ifdef SER_PARITY_EN
          w_nxt_parity    = (^r_hold_q) ^ 1'(PARITY_ODD);
`endif
          if (LSB_FIRST != 0) begin
            w_nxt_data_out = r_hold_q[0];
          end else begin
            w_nxt_data_out = r_hold_q[DATA_WIDTH-1];
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (enable) begin
          if (r_bit_cnt == LAST_CNT) begin
`ifdef SER_PARITY_EN
            w_nxt_state    = S_PARITY;
            w_nxt_data_out = r_parity;
`else
            w_nxt_state    = S_IDLE;
            w_nxt_done     = 1'b1;
            w_nxt_data_out = IDLE_LEVEL;
`endif
          end else begin
            w_nxt_bit_cnt = r_bit_cnt + CNT_W'(1);
            // The bit after the current one sits at index 1 (LSB-first)
            // or DATA_WIDTH-2 (MSB-first) of the not-yet-shifted word.
            if (LSB_FIRST != 0) begin
              w_nxt_shift_q  = {1'b0, r_shift_q[DATA_WIDTH-1:1]};
              w_nxt_data_out = r_shift_q[1];
            end else begin
              w_nxt_shift_q  = {r_shift_q[DATA_WIDTH-2:0], 1'b0};
              w_nxt_data_out = r_shift_q[DATA_WIDTH-2];
            end
          end
        end else begin
          w_nxt_state = S_SHIFT;
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (enable) begin
          w_nxt_state    = S_IDLE;
          w_nxt_done     = 1'b1;
          w_nxt_data_out = IDLE_LEVEL;
        end else begin
          w_nxt_state = S_PARITY;
        end
      end
`endif
      default: begin
        w_nxt_state    = S_IDLE;
        w_nxt_data_out = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer. Two instances (LSB-first and MSB-first) share
// the same stimulus. A frame-level reference (held word, frame word, bit
// index) predicts all outputs on every cycle. Literal expectations pin the
// reference.
module tb_param_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid;
  logic         enable;
  logic         l_ready, l_data_out, l_busy, l_done;
  logic         m_ready_o, m_data_out_o, m_busy_o, m_done_o;

  int checks   = 0;
  int failures = 0;

  param_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1), .IDLE_LEVEL(1'b1), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(l_ready),
    .enable(enable), .data_out(l_data_out), .busy(l_busy), .done(l_done)
  );

  param_serializer #(.DATA_WIDTH(W), .LSB_FIRST(0), .IDLE_LEVEL(1'b1), .PARITY_ODD(0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(m_ready_o),
    .enable(enable), .data_out(m_data_out_o), .busy(m_busy_o), .done(m_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bit k of a frame is data bit k (LSB-first) or W-1-k, and
  // position W is even parity of the word.
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit lsb);
    if (idx >= W) return ^w;
    else if (lsb) return w[idx];
    else return w[W-1-idx];
  endfunction

  bit           started = 1'b0;
  bit           r_hold_full;
  logic [W-1:0] r_hold_word;
  bit           r_active;
  logic [W-1:0] r_word;
  int           r_idx;
  bit           r_done_exp;

  // Reference update at each edge from the inputs the DUT also samples.
  always @(posedge clk) begin
    bit acc;
    if (!rst) begin
      r_hold_full = 1'b0;
      r_active    = 1'b0;
      r_idx       = 0;
      r_done_exp  = 1'b0;
    end else begin
      acc        = valid && !r_hold_full;
      r_done_exp = 1'b0;
      if (r_active) begin
        if (enable) begin
          if (r_idx == FRAME_LEN - 1) begin
            r_active   = 1'b0;
            r_done_exp = 1'b1;
          end else begin
            r_idx++;
          end
        end
      end else if (r_hold_full) begin
        r_word      = r_hold_word;
        r_active    = 1'b1;
        r_idx       = 0;
        r_hold_full = 1'b0;
      end
      if (acc) begin
        r_hold_full = 1'b1;
        r_hold_word = data_in;
      end
    end
    started = 1'b1;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("lsb_ready", l_ready, !r_hold_full);
      chk("lsb_busy", l_busy, r_active);
      chk("lsb_done", l_done, r_done_exp);
      chk("lsb_data_out", l_data_out, r_active ? exp_bit(r_word, r_idx, 1'b1) : 1'b1);
      chk("msb_ready", m_ready_o, !r_hold_full);
      chk("msb_busy", m_busy_o, r_active);
      chk("msb_done", m_done_o, r_done_exp);
      chk("msb_data_out", m_data_out_o, r_active ? exp_bit(r_word, r_idx, 1'b0) : 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    enable = 1'b1;
    cyc(1);
    enable = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    for (int i = 0; i < 200 && !l_ready; i++) cyc(1);
    chk("send_ready_timeout", l_ready, 1'b1);
    valid   = 1'b1;
    data_in = d;
    cyc(1);
    valid   = 1'b0;
    data_in = W'($urandom);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !l_busy; i++) cyc(1);
    chk("wait_busy_timeout", l_busy, 1'b1);
  endtask

  task automatic drain(input int gap);
    for (int p = 0; p < 60; p++) begin
      if (!l_busy && l_ready) break;
      cyc(gap);
      pulse();
    end
    chk("drain_idle_busy", l_busy, 1'b0);
    chk("drain_idle_ready", l_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] seq_l;
    logic [W-1:0] seq_m;
    rst = 1'b0; valid = 1'b1; data_in = 8'h4B; enable = 1'b0;

    // 1. Reset with valid asserted: nothing accepted.
    cyc(2);
    chk("rst_data_out", l_data_out, 1'b1);
    chk("rst_busy", l_busy, 1'b0);
    chk("rst_done", l_done, 1'b0);
    chk("rst_ready", l_ready, 1'b1);
    rst = 1'b1; valid = 1'b0;
    cyc(3);
    chk("rst_no_accept_busy", l_busy, 1'b0);

    // 2/3. Word 8'h4B, enables 10 cycles apart, both bit orders.
    send(8'h4B);
    wait_busy();
    seq_l = '0; seq_m = '0;
    for (int k = 0; k < W; k++) begin
      cyc(9);
      seq_l = {seq_l[W-2:0], l_data_out};
      seq_m = {seq_m[W-2:0], m_data_out_o};
      pulse();
    end
    chk("lsb_sequence", seq_l, 8'b11010010);
    chk("msb_sequence", seq_m, 8'b01001011);
`ifdef SER_PARITY_EN
    chk("parity_bit", l_data_out, 1'b0);
    chk("parity_no_done", l_done, 1'b0);
    cyc(9);
    pulse();
`endif
    chk("last_done", l_done, 1'b1);
    chk("last_busy", l_busy, 1'b0);
    chk("last_data_out", l_data_out, 1'b1);
    cyc(1);
    chk("done_one_cycle", l_done, 1'b0);

    // 4. Back-to-back A5 then 3C; a third word waits for ready.
    send(8'hA5);
    wait_busy();
    send(8'h3C);
    chk("held_ready_low", l_ready, 1'b0);
    valid = 1'b1; data_in = 8'hFF;
    for (int p = 0; p < 20; p++) begin
      cyc(1);
      pulse();
      if (l_done) break;
    end
    chk("a5_done", l_done, 1'b1);
    chk("a5_idle_gap", l_busy, 1'b0);
    cyc(1);
    chk("3c_loaded_busy", l_busy, 1'b1);
    chk("3c_first_bit_lsb", l_data_out, 1'b0);
    chk("3c_first_bit_msb", m_data_out_o, 1'b0);
    cyc(2);
    valid = 1'b0;
    drain(2);

    // 5. Enables in IDLE, then irregular gaps.
    for (int k = 0; k < 3; k++) pulse();
    chk("idle_enable_no_busy", l_busy, 1'b0);
    send(8'h96);
    wait_busy();
    cyc(3);  pulse();
    cyc(17); pulse();
    cyc(1);  pulse();
    drain(1);

    // 6. Reset mid-frame with a held word.
    send(8'h5A);
    wait_busy();
    for (int k = 0; k < 4; k++) begin
      cyc(2);
      pulse();
    end
    send(8'hC3);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(5);
    chk("midrst_busy", l_busy, 1'b0);
    chk("midrst_ready", l_ready, 1'b1);
    chk("midrst_data_out", l_data_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised successor to the UART transmit serializer. It accepts a parallel word over a valid/ready handshake into a one-entry holding register, then shifts the word out one bit per `enable` tick. Bit order and data width are configurable. The block generates its own `busy` flag and a `done` pulse, and it supports back-to-back frames without a gap in acceptance. It sits between the TX data source and the UART TX framing FSM, which supplies the baud `enable` tick.

Parameters:
DATA_WIDTH, 8, number of data bits per word (legal range 2..32).
LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit DATA_WIDTH-1 shifted first.
IDLE_LEVEL, 1'b1, value driven on `data_out` when no word is being shifted.
PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when SER_PARITY_EN is defined.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
data_in  input  DATA_WIDTH  parallel word to send
valid  input  1  data_in is valid this cycle
ready  output  1  holding register empty; word accepted when valid && ready
enable  input  1  bit-period tick from baud generator; one-cycle pulses
data_out  output  1  registered serial bit
busy  output  1  1 while a word is in the shifter (state != IDLE)
done  output  1  one-cycle pulse when the last bit period of a word completes

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE, hold_full = 0, bit_cnt = 0.
  - Outputs: data_out = IDLE_LEVEL, busy = 0, done = 0, ready = 1.
  - Reset has priority over all other events; a frame in progress is discarded with no `done` pulse.
- `ready` equals `!hold_full`, decoded from the register with no combinational path from `valid`.
- Accept: valid && ready at an edge → hold_q <= data_in, hold_full <= 1. `data_in` is ignored when `valid` = 0 or `ready` = 0.
- States are IDLE, SHIFT, and PARITY (PARITY exists only with SER_PARITY_EN).
- IDLE:
  - data_out = IDLE_LEVEL; `enable` is ignored.
  - If hold_full: shift_q <= hold_q, hold_full <= 0, bit_cnt <= 0, data_out <= first bit, state <= SHIFT.
  - Latency: a word accepted in cycle N loads the shifter at N+1, its first bit is visible at N+2, and busy = 1 from N+2.
- SHIFT:
  - data_out holds the current bit until `enable`.
  - On enable with bit_cnt < DATA_WIDTH-1: bit_cnt++, data_out <= next bit in the configured order.
  - On enable with bit_cnt == DATA_WIDTH-1: go to PARITY if enabled; otherwise go to IDLE, pulse done for 1 cycle, and set data_out <= IDLE_LEVEL.
- Each bit is held for exactly one enable-to-enable period. The first bit is held from load until the first `enable`, so the upstream FSM asserts `enable` only after seeing busy.
- Holding register: a new word may be accepted at any time while in SHIFT/PARITY. After `done` the block spends one IDLE cycle, then loads the held word.
- A load and an accept never occur in the same cycle, because a load requires hold_full, which holds ready = 0.
- bit_cnt width is $clog2(DATA_WIDTH); it does not wrap, because the terminal count forces a state exit.
- `done` and `busy` never overlap with a stale word: `done` is asserted in the cycle busy falls.

Optional Feature:
Macro SER_PARITY_EN.
- Defined:
  - Parity is computed at shifter load as ^hold_q XOR PARITY_ODD.
  - After the last data bit, the state goes to PARITY and data_out <= parity bit for one enable period.
  - The next enable → IDLE and done pulse. A frame is DATA_WIDTH+1 bit periods.
- Undefined: the PARITY state, the parity register and PARITY_ODD logic are absent, and a frame is DATA_WIDTH bit periods.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles with valid = 1 and data_in = 8'h4B → data_out = 1, busy = 0, done = 0, ready = 1, and no word accepted.
2. Single word, LSB_FIRST = 1: accept 8'b01001011, then issue 8 enable pulses 10 cycles apart → data_out sequence 1,1,0,1,0,0,1,0 with each bit held until its enable. `done` is asserted for 1 cycle on the 8th enable edge, busy falls simultaneously, and data_out returns to 1.
3. LSB_FIRST = 0, same word → sequence 0,1,0,0,1,0,1,1, with identical timing.
4. Back-to-back: accept 8'hA5 and, while busy, accept 8'h3C; ready goes 0 until the 3C load. After the A5 `done` there is exactly one IDLE cycle, then 3C shifts. A third valid during 3C's frame is held off while ready = 0.
5. Irregular enable (gaps of 3, 17, 1 cycles) and enable asserted in IDLE → bits advance only on enable in SHIFT, and IDLE enables produce no shift and no `done`.
6. Reset mid-frame after 4 bits, plus a held word → after reset, state is IDLE, the held word is lost, there is no `done`, and data_out = 1. With SER_PARITY_EN and PARITY_ODD = 0, word 8'h4B gives a 9th bit of 0 before `done`.
